// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO of {pc, inst}, with synchronous flush.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_pop;

  // A pop in the flush cycle is dropped; the flush empties everything anyway.
  assign do_pop = pop && (count != '0) && !flush;
  assign rdata  = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding memory request FSM feeding a FIFO to decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] pc_addr,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state, next;
  logic [XLEN-1:0] addr_q;
  logic [CW-1:0]   count;
  logic            accept, push;
  fetch_entry_t    wdata, head;

  // Only accept when the buffer has room for the result, so a push never overflows.
  assign pc_ready  = (state == IDLE) && (count < CW'(DEPTH)) && !flush;
  assign accept    = pc_valid && pc_ready;
  assign push      = (state == WAIT) && imem_rvalid && !flush;
  assign imem_req  = (state == REQ);
  assign imem_addr = {addr_q[XLEN-1:2], 2'b00};
  assign wdata     = '{pc: addr_q, inst: imem_rdata};
  assign id_valid  = (count != '0);
  assign id_inst   = head.inst;
  assign id_pc     = head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state <= next;
      if (accept) addr_q <= pc_addr;
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (accept) next = REQ;
      REQ: begin
        if (flush)         next = imem_gnt ? DROP : IDLE;
        else if (imem_gnt) next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) next = IDLE;
        else if (flush)  next = DROP;
      end
      // A granted request must still return its data; swallow it before going idle.
      DROP: if (imem_rvalid) next = IDLE;
      default: next = IDLE;
    endcase
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (id_valid && id_ready),
    .flush (flush),
    .wdata (wdata),
    .rdata (head),
    .count (count)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run against a queue model.
module tb_inst_fetch;
  localparam int DEPTH = 2;

  logic        clk, rst_n;
  logic        pc_valid, pc_ready, flush;
  logic [31:0] pc_addr;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc;

  int vectors = 0;
  int miscompares = 0;

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_valid(pc_valid), .pc_addr(pc_addr), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one fetch with immediate grant and data one cycle later; optionally pops at the data cycle.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic pop_at_resp);
    int n = 0;
    pc_valid = 1'b1; pc_addr = a; #1;
    while (!pc_ready && n < 50) begin next_cycle(); #1; n++; end
    vectors++;
    if (pc_ready !== 1'b1) begin
      miscompares++; $display("FAIL fetch_accept: pc_ready=%b required 1 for addr %h", pc_ready, a);
    end
    next_cycle();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = d; id_ready = pop_at_resp;
    next_cycle();
    imem_rvalid = 1'b0; id_ready = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({imem_req, imem_addr, id_valid, id_inst, id_pc} !== '0) begin
      miscompares++; $display("FAIL reset_outputs: req=%b addr=%h vld=%b inst=%h pc=%h required all 0",
        imem_req, imem_addr, id_valid, id_inst, id_pc);
    end
    rst_n = 1'b1;
    next_cycle(); #1;
    vectors++;
    if (pc_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_pc_ready: got %b required 1", pc_ready);
    end
  endtask

  task automatic test_basic();
    pc_valid = 1'b1; pc_addr = 32'h0; imem_gnt = 1'b1;
    next_cycle();
    pc_valid = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++; $display("FAIL basic_req: req=%b addr=%h required 1/00000000", imem_req, imem_addr);
    end
    next_cycle();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    next_cycle();
    imem_rvalid = 1'b0;
    vectors++;
    if (id_valid !== 1'b1 || id_inst !== 32'h0050_0093 || id_pc !== 32'h0) begin
      miscompares++; $display("FAIL basic_deliver: vld=%b inst=%h pc=%h required 1/00500093/00000000",
        id_valid, id_inst, id_pc);
    end
    id_ready = 1'b1;
    next_cycle();
    id_ready = 1'b0;
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_pop: id_valid=%b required 0", id_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0, d1, d2;
    d0 = $urandom; d1 = $urandom; d2 = $urandom;
    id_ready = 1'b0;
    fetch(32'h0, d0, 1'b0);
    fetch(32'h4, d1, 1'b0);
    pc_valid = 1'b1; pc_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (pc_ready !== 1'b0 || imem_req !== 1'b0 || id_pc !== 32'h0) begin
        miscompares++; $display("FAIL full_stall: pc_ready=%b req=%b id_pc=%h required 0/0/00000000",
          pc_ready, imem_req, id_pc);
      end
      next_cycle();
    end
    id_ready = 1'b1;
    next_cycle();
    id_ready = 1'b0; #1;
    vectors++;
    if (pc_ready !== 1'b1 || id_pc !== 32'h4 || id_inst !== d1) begin
      miscompares++; $display("FAIL full_release: pc_ready=%b id_pc=%h inst=%h required 1/00000004/%h",
        pc_ready, id_pc, id_inst, d1);
    end
    next_cycle();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      miscompares++; $display("FAIL third_req: req=%b addr=%h required 1/00000008", imem_req, imem_addr);
    end
    next_cycle();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = d2;
    next_cycle();
    imem_rvalid = 1'b0; id_ready = 1'b1;
    next_cycle();
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_inst !== d2) begin
      miscompares++; $display("FAIL third_deliver: vld=%b pc=%h inst=%h required 1/00000008/%h",
        id_valid, id_pc, id_inst, d2);
    end
    next_cycle();
    id_ready = 1'b0;
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++; $display("FAIL drain: id_valid=%b required 0", id_valid);
    end
  endtask

  task automatic test_gnt_stall();
    pc_valid = 1'b1; pc_addr = 32'h10; imem_gnt = 1'b0;
    next_cycle();
    pc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
        miscompares++; $display("FAIL stall_hold[%0d]: req=%b addr=%h required 1/00000010", i, imem_req, imem_addr);
      end
      imem_gnt = (i == 3);
      next_cycle();
    end
    imem_gnt = 1'b0;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++; $display("FAIL stall_drop_req: req=%b required 0", imem_req);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    next_cycle();
    imem_rvalid = 1'b0;
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_inst !== 32'h1234_5678) begin
      miscompares++; $display("FAIL stall_deliver: vld=%b pc=%h inst=%h required 1/00000010/12345678",
        id_valid, id_pc, id_inst);
    end
    id_ready = 1'b1;
    next_cycle();
    id_ready = 1'b0;
  endtask

  task automatic test_flush_wait();
    logic [31:0] d;
    d = $urandom;
    pc_valid = 1'b1; pc_addr = 32'h20;
    next_cycle();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0; flush = 1'b1;
    next_cycle();
    flush = 1'b0; #1;
    vectors++;
    if (pc_ready !== 1'b0 || imem_req !== 1'b0) begin
      miscompares++; $display("FAIL drop_state: pc_ready=%b req=%b required 0/0", pc_ready, imem_req);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    next_cycle();
    imem_rvalid = 1'b0; #1;
    vectors++;
    if (id_valid !== 1'b0 || pc_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_discard: id_valid=%b pc_ready=%b required 0/1", id_valid, pc_ready);
    end
    fetch(32'h40, d, 1'b0);
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_inst !== d) begin
      miscompares++; $display("FAIL flush_refetch: vld=%b pc=%h inst=%h required 1/00000040/%h",
        id_valid, id_pc, id_inst, d);
    end
    id_ready = 1'b1;
    next_cycle();
    id_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [6];
    for (int i = 0; i < 6; i++) d[i] = $urandom;
    fetch(32'h100, d[0], 1'b0);
    for (int k = 1; k < 6; k++) begin
      fetch(32'h100 + 32'(4 * k), d[k], 1'b1);
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'h100 + 32'(4 * k) || id_inst !== d[k]) begin
        miscompares++; $display("FAIL push_pop[%0d]: vld=%b pc=%h inst=%h required 1/%h/%h",
          k, id_valid, id_pc, id_inst, 32'h100 + 32'(4 * k), d[k]);
      end
    end
    id_ready = 1'b1;
    next_cycle();
    id_ready = 1'b0;
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++; $display("FAIL push_pop_count: id_valid=%b required 0", id_valid);
    end
  endtask

  task automatic test_reset_mid();
    fetch(32'h1F0, $urandom | 32'h1, 1'b0);
    pc_valid = 1'b1; pc_addr = 32'h200;
    next_cycle();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0; rst_n = 1'b0; #1;
    vectors++;
    if ({imem_req, imem_addr, id_valid, id_inst, id_pc} !== '0) begin
      miscompares++; $display("FAIL async_reset: req=%b addr=%h vld=%b inst=%h pc=%h required all 0",
        imem_req, imem_addr, id_valid, id_inst, id_pc);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    next_cycle();
    imem_rvalid = 1'b0; #1;
    vectors++;
    if (id_valid !== 1'b0 || imem_req !== 1'b0 || pc_ready !== 1'b1) begin
      miscompares++; $display("FAIL stray_rvalid: vld=%b req=%b pc_ready=%b required 0/0/1",
        id_valid, imem_req, pc_ready);
    end
  endtask

  // Randomized run: the bench plays PC, memory and decode; the model is a queue of
  // delivered {pc,inst} plus a record of the one fetch in flight.
  task automatic test_random();
    logic [63:0] exp_q [$];
    logic        busy = 0, granted = 0, live = 0;
    logic [31:0] cur = '0;
    int          dly = 0;
    logic        fl, pv, idr, g, rv, exp_ready, exp_req;
    logic [31:0] pa, rd;
    for (int c = 0; c < 3000; c++) begin
      fl  = ($urandom % 20) == 0;
      pv  = $urandom % 2;
      pa  = $urandom;
      idr = ($urandom % 3) != 0;
      g   = ($urandom % 3) != 0;
      rd  = $urandom;
      rv  = 1'b0;
      if (granted) begin
        if (dly == 0) rv = 1'b1; else dly--;
      end else if (($urandom % 10) == 0) rv = 1'b1;
      pc_valid = pv; pc_addr = pa; flush = fl; id_ready = idr;
      imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
      #1;
      exp_ready = !busy && (exp_q.size() < DEPTH) && !fl;
      exp_req   = busy && !granted;
      vectors++;
      if (pc_ready !== exp_ready) begin
        miscompares++; $display("FAIL rnd_pc_ready @%0d: got %b required %b", c, pc_ready, exp_ready);
      end
      vectors++;
      if (imem_req !== exp_req) begin
        miscompares++; $display("FAIL rnd_imem_req @%0d: got %b required %b", c, imem_req, exp_req);
      end
      if (exp_req) begin
        vectors++;
        if (imem_addr !== {cur[31:2], 2'b00}) begin
          miscompares++; $display("FAIL rnd_imem_addr @%0d: got %h required %h", c, imem_addr, {cur[31:2], 2'b00});
        end
      end
      vectors++;
      if (id_valid !== (exp_q.size() != 0)) begin
        miscompares++; $display("FAIL rnd_id_valid @%0d: got %b required %b", c, id_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0 && idr && !fl) begin
        vectors++;
        if ({id_pc, id_inst} !== exp_q[0]) begin
          miscompares++; $display("FAIL rnd_pop @%0d: got %h required %h", c, {id_pc, id_inst}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (granted && rv) begin
        if (live && !fl) exp_q.push_back({cur, rd});
        busy = 0; granted = 0;
      end
      if (exp_req && g) begin
        granted = 1; dly = $urandom % 3;
      end
      if (fl) begin
        exp_q.delete();
        if (busy) begin
          if (granted) live = 0; else busy = 0;
        end
      end
      if (pv && exp_ready) begin
        busy = 1; live = 1; granted = 0; cur = pa;
      end
      next_cycle();
    end
    pc_valid = 0; flush = 0; id_ready = 0; imem_gnt = 0; imem_rvalid = 0;
  endtask

  initial begin
    rst_n = 1'b0; pc_valid = 0; pc_addr = '0; flush = 0; imem_gnt = 0;
    imem_rvalid = 0; imem_rdata = '0; id_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_gnt_stall();
    test_flush_wait();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
